// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - command/response bundle between the arbiter and the SRAM controller
//
// Purpose : groups the single-transaction controller handshake so the arbiter
//           and the controller (or a bench model of it) connect with one port.
// Signals :
//   mem    command strobe, one cycle per transaction      (arbiter -> controller)
//   rw     direction, 1=read 0=write                      (arbiter -> controller)
//   addr   AW-bit address                                 (arbiter -> controller)
//   wdata  DW-bit write data                              (arbiter -> controller)
//   ready  controller idle/ready                          (controller -> arbiter)
//   rdata  DW-bit registered read data                    (controller -> arbiter)
// Modports: master = arbiter side, slave = controller side.

interface sram_arbiter_if #(
    parameter int AW = 19,
    parameter int DW = 8
);
    logic          mem;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic [DW-1:0] rdata;

    modport master (
        output mem,
        output rw,
        output addr,
        output wdata,
        input  ready,
        input  rdata
    );

    modport slave (
        input  mem,
        input  rw,
        input  addr,
        input  wdata,
        output ready,
        output rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter in front of a single SRAM controller
//
// Purpose : shares one SRAM controller between two requesters. One transaction
//           is in flight at a time; grants alternate when both ports contend.
//           Every output is a register.
// Ports   :
//   clk               system clock
//   reset             asynchronous, active-low reset
//   req0/req1         request, held by the requester until its done pulse
//   rw0/rw1           direction, 1=read 0=write
//   addr0/addr1       AW-bit address
//   wdata0/wdata1     DW-bit write data
//   done0/done1       one-cycle completion pulse to the owning port
//   rdata0/rdata1     read data, held until that port's next read completes
//   busy              high whenever the FSM is not IDLE
//   err               watchdog pulse, coincident with done (constant 0 by default)
//   ctrl              sram_arbiter_if.master towards the controller
// Option  : define SRAM_ARB_TIMEOUT_EN to enable the WAIT watchdog of TIMEOUT cycles.

module sram_arbiter #(
    parameter int AW      = 19,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          req0,
    input  logic          rw0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          done0,
    output logic [DW-1:0] rdata0,

    input  logic          req1,
    input  logic          rw1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          done1,
    output logic [DW-1:0] rdata1,

    output logic          busy,
    output logic          err,

    sram_arbiter_if.master ctrl
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    logic   owner;       // port that holds the current transaction
    logic   last_grant;  // port granted most recently; loses the next tie
    logic   wait_first;  // first WAIT cycle: controller has not left idle yet
    logic   pick;        // port that would be granted this cycle

`ifdef SRAM_ARB_TIMEOUT_EN
    // At least 4 bits, wide enough to hold TIMEOUT-1.
    localparam int CW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
`else
    // TIMEOUT is kept in the parameter list so both builds share one instance signature.
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
`endif

    // A single requester wins outright; on a tie the port that was not granted last wins.
    assign pick = (req0 && req1) ? ~last_grant : req1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            wait_first <= 1'b0;
            ctrl.mem   <= 1'b0;
            ctrl.rw    <= 1'b1;
            ctrl.addr  <= '0;
            ctrl.wdata <= '0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
`ifdef SRAM_ARB_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            // Pulsed outputs default low; they are raised only on the edge into DONE.
            done0 <= 1'b0;
            done1 <= 1'b0;
            err   <= 1'b0;

            case (state)
                IDLE: begin
                    // A grant needs the controller idle as well, so a cycle left
                    // running across a reset is allowed to finish first.
                    if (ctrl.ready && (req0 || req1)) begin
                        owner      <= pick;
                        last_grant <= pick;
                        ctrl.rw    <= pick ? rw1    : rw0;
                        ctrl.addr  <= pick ? addr1  : addr0;
                        ctrl.wdata <= pick ? wdata1 : wdata0;
                        ctrl.mem   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    ctrl.mem   <= 1'b0;
                    wait_first <= 1'b1;
`ifdef SRAM_ARB_TIMEOUT_EN
                    wait_cnt   <= '0;
`endif
                    state      <= WAIT;
                end

                WAIT: begin
                    wait_first <= 1'b0;
                    // ready is still the pre-command idle level on the first
                    // WAIT cycle, so it only counts from the second one on.
                    if (!wait_first && ctrl.ready) begin
                        state <= DONE;
                        if (owner) begin
                            done1 <= 1'b1;
                            if (ctrl.rw) begin
                                rdata1 <= ctrl.rdata;
                            end
                        end else begin
                            done0 <= 1'b1;
                            if (ctrl.rw) begin
                                rdata0 <= ctrl.rdata;
                            end
                        end
                    end
`ifdef SRAM_ARB_TIMEOUT_EN
                    else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        // Watchdog expiry: complete without touching read data.
                        state <= DONE;
                        err   <= 1'b1;
                        if (owner) begin
                            done1 <= 1'b1;
                        end else begin
                            done0 <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                DONE: begin
                    // No grant here: this leaves one idle gap cycle between transactions.
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - randomized bench for sram_arbiter against an edge-indexed transaction model

`timescale 1ns/1ps

module tb_sram_arbiter;

    localparam int AW   = 19;
    localparam int DW   = 8;
    localparam int TO   = 15;
    localparam int NCYC = 800;

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          rq [2];
    logic          rw [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    logic          done0, done1, busy, err;
    logic [DW-1:0] rdata0, rdata1;

    sram_arbiter_if #(.AW(AW), .DW(DW)) cif ();

    sram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .reset  (rst_n),
        .req0   (rq[0]),
        .rw0    (rw[0]),
        .addr0  (ad[0]),
        .wdata0 (wd[0]),
        .done0  (done0),
        .rdata0 (rdata0),
        .req1   (rq[1]),
        .rw1    (rw[1]),
        .addr1  (ad[1]),
        .wdata1 (wd[1]),
        .done1  (done1),
        .rdata1 (rdata1),
        .busy   (busy),
        .err    (err),
        .ctrl   (cif)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem"},    32'(cif.mem),   32'd0);
        chk({tag, "_rw"},     32'(cif.rw),    32'd1);
        chk({tag, "_addr"},   32'(cif.addr),  32'd0);
        chk({tag, "_wdata"},  32'(cif.wdata), 32'd0);
        chk({tag, "_done0"},  32'(done0),     32'd0);
        chk({tag, "_done1"},  32'(done1),     32'd0);
        chk({tag, "_rdata0"}, 32'(rdata0),    32'd0);
        chk({tag, "_rdata1"}, 32'(rdata1),    32'd0);
        chk({tag, "_busy"},   32'(busy),      32'd0);
        chk({tag, "_err"},    32'(err),       32'd0);
    endtask

    // Transaction model: a transaction granted at edge g completes at the first
    // edge >= g+3 that sees ready (or at g+1+TO with the watchdog); the next
    // grant is possible from edge d+2. Outputs are predicted per edge from that.
    logic          m_act, m_own, m_last, m_rw, m_to, dn;
    int            m_g, m_d, t_free;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rexp;
    logic          e_rw;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [DW-1:0] e_rd [2];
    logic [DW-1:0] ref_mem [int];
    logic          grant_ev [2];

    // Controller model and requesters.
    logic [DW-1:0] sram [int];
    int            c_lag, c_busy;
    logic          c_seen;
    logic          pend [2];
    op_t           dq [2][$];
    op_t           op;
    int            n_dut_done, n_mod_done, rst_hold;
    logic          rst_tested;

    initial begin
        rq = '{1'b0, 1'b0};
        rw = '{1'b1, 1'b1};
        ad = '{'0, '0};
        wd = '{'0, '0};
        pend = '{1'b0, 1'b0};
        cif.ready = 1'b1;
        cif.rdata = '0;
        c_lag = 0; c_busy = 0; c_seen = 1'b0;
        m_act = 1'b0; m_own = 1'b0; m_last = 1'b1; m_rw = 1'b1; m_to = 1'b0;
        m_g = 0; m_d = -1; t_free = 0;
        m_addr = '0; m_wd = '0; m_rexp = '0;
        e_rw = 1'b1; e_addr = '0; e_wd = '0; e_rd = '{'0, '0};
        n_dut_done = 0; n_mod_done = 0; rst_hold = 0; rst_tested = 1'b0;

        dq[0].push_back('{rw: 1'b0, a: AW'(32'h12), d: 8'hA5});
        dq[0].push_back('{rw: 1'b1, a: AW'(32'h12), d: 8'h00});
        dq[0].push_back('{rw: 1'b1, a: AW'(32'h10), d: 8'h00});
        dq[1].push_back('{rw: 1'b1, a: AW'(32'h20), d: 8'h00});

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 1; k <= NCYC; k++) begin
            @(posedge clk);
            #1;
            dn = 1'b0;
            grant_ev = '{1'b0, 1'b0};

            if (rst_n) begin
                if (m_act && m_d >= 0 && k > m_d) begin
                    m_act = 1'b0;
                end
                if (m_act && m_d < 0) begin
                    if (k >= m_g + 3 && cif.ready) begin
                        m_d = k; m_to = 1'b0;
                    end
`ifdef SRAM_ARB_TIMEOUT_EN
                    else if (k == m_g + 1 + TO) begin
                        m_d = k; m_to = 1'b1;
                    end
`endif
                    if (m_d == k) begin
                        dn = 1'b1;
                        t_free = k + 2;
                        n_mod_done++;
                        if (m_rw && !m_to) e_rd[m_own] = m_rexp;
                    end
                end
                if (!m_act && k >= t_free && cif.ready && (rq[0] || rq[1])) begin
                    m_own  = (rq[0] && rq[1]) ? ~m_last : rq[1];
                    m_last = m_own;
                    m_act  = 1'b1;
                    m_g    = k;
                    m_d    = -1;
                    m_to   = 1'b0;
                    m_rw   = rw[m_own];
                    m_addr = ad[m_own];
                    m_wd   = wd[m_own];
                    e_rw = m_rw; e_addr = m_addr; e_wd = m_wd;
                    grant_ev[m_own] = 1'b1;
                    if (m_rw) m_rexp = ref_mem.exists(int'(m_addr)) ? ref_mem[int'(m_addr)] : '0;
                    else      ref_mem[int'(m_addr)] = m_wd;
                end
            end

            chk("ctrl_mem",   32'(cif.mem),   32'(m_act && k == m_g));
            chk("busy",       32'(busy),      32'(m_act));
            chk("done0",      32'(done0),     32'(dn && !m_own));
            chk("done1",      32'(done1),     32'(dn && m_own));
            chk("err",        32'(err),       32'(dn && m_to));
            chk("ctrl_rw",    32'(cif.rw),    32'(e_rw));
            chk("ctrl_addr",  32'(cif.addr),  32'(e_addr));
            chk("ctrl_wdata", 32'(cif.wdata), 32'(e_wd));
            chk("rdata0",     32'(rdata0),    32'(e_rd[0]));
            chk("rdata1",     32'(rdata1),    32'(e_rd[1]));
            n_dut_done += int'(done0) + int'(done1);

            if (dn) begin
                pend[m_own] = 1'b0;
                rq[m_own]   = 1'b0;
            end

            // Controller: acts on the command it sampled at this edge.
            if (c_seen) begin
                if (cif.rw) cif.rdata = sram.exists(int'(cif.addr)) ? sram[int'(cif.addr)] : '0;
                else        sram[int'(cif.addr)] = cif.wdata;
                c_lag  = $urandom_range(0, 1);
                c_busy = $urandom_range(1, 3);
`ifdef SRAM_ARB_TIMEOUT_EN
                if ($urandom_range(0, 7) == 0) c_busy = TO + 4;
`endif
            end
            if (c_lag > 0) begin
                cif.ready = 1'b1; c_lag--;
            end else if (c_busy > 0) begin
                cif.ready = 1'b0; c_busy--;
            end else begin
                cif.ready = 1'b1;
            end
            c_seen = cif.mem;

            // Asynchronous reset in the middle of WAIT, with the controller still busy.
            if (!rst_tested && k > 300 && m_act && m_d < 0 && k >= m_g + 2) begin
                rst_tested = 1'b1;
                c_lag = 0; c_busy = 5; cif.ready = 1'b0;
                rst_n = 1'b0;
                #1;
                chk_reset_outputs("midreset");
                m_act = 1'b0; m_last = 1'b1; t_free = 0;
                e_rw = 1'b1; e_addr = '0; e_wd = '0; e_rd = '{'0, '0};
                pend = '{1'b0, 1'b0};
                rq = '{1'b0, 1'b0};
                rst_hold = 2;
            end else if (!rst_n && rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end

            // Requesters: dense contention early, sparser traffic later.
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && grant_ev[p] && $urandom_range(0, 3) == 0) begin
                    rq[p] = 1'b0;
                    rw[p] = 1'($urandom_range(0, 1));
                    ad[p] = AW'($urandom_range(0, 15));
                    wd[p] = DW'($urandom);
                end else if (!pend[p] && rst_n && (k < 150 || $urandom_range(0, 2) == 0)) begin
                    if (dq[p].size() > 0) begin
                        op = dq[p].pop_front();
                    end else begin
                        op.rw = 1'($urandom_range(0, 1));
                        op.a  = AW'($urandom_range(0, 15));
                        op.d  = DW'($urandom);
                    end
                    rq[p] = 1'b1; rw[p] = op.rw; ad[p] = op.a; wd[p] = op.d;
                    pend[p] = 1'b1;
                end
            end
        end

        chk("done_count", 32'(n_dut_done), 32'(n_mod_done));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
